attocore_cpu: RTL and testbench
===============================

Name: attocore_cpu

Overview:
- Minimal 8-bit accumulator CPU with a 16-bit address bus and a single shared bidirectional 8-bit data bus.
- Fetches, decodes and executes a small fixed ISA from external memory.
- At top level it is paired with a 256-byte combinational ROM/RAM:
  - the ROM is addressed by address_bus[7:0];
  - the ROM drives data_bus only while data_dir=1.

Parameters:
- RESET_VECTOR, 16'h0000, PC value loaded on reset.

Ports:
- clock  input  1  Single system clock; all state changes on the rising edge.
- reset  input  1  Synchronous, active-high reset.
- data_dir  output  1  1 = read (memory drives data_bus), 0 = write (core drives data_bus).
- data_bus  inout  8  Shared data bus. Core drives A when data_dir=0, else high-Z.
- address_bus  output  16  Memory address for the current cycle.

Behaviour:
- Registers:
  - PC[15:0]
  - A[7:0] accumulator
  - flags Z and C
  - IR[7:0]
  - OP[15:0] operand latch
  - state
- Memory model: read data is valid combinationally in the same cycle and is sampled at the rising edge.
- Reset (synchronous, while reset=1):
  - PC=RESET_VECTOR, A=0, Z=0, C=0, IR=0, OP=0
  - state=FETCH, data_dir=1, address_bus=RESET_VECTOR, data_bus high-Z
- States, one cycle each:
  - FETCH: address_bus=PC. IR<=data_bus, PC<=PC+1 (16-bit wrap, FFFF->0000).
    - 1-byte ops execute here; next state FETCH.
    - Imm ops go to IMM; addr ops go to ALO.
  - IMM: address_bus=PC. Execute using data_bus as imm8; PC+1; next FETCH.
  - ALO: address_bus=PC. OP[7:0]<=data_bus; PC+1; next AHI.
  - AHI: address_bus=PC. OP[15:8]<=data_bus; PC+1.
    - Jumps resolve here: PC<=OP if taken, else PC+1. Next FETCH.
    - Memory ops go to MEM.
  - MEM: address_bus=OP.
    - Reads: data_dir=1, result latched at the edge.
    - STA: data_dir=0 for exactly this cycle, data_bus=A.
    - Next FETCH.
  - HALT: address_bus=PC, data_dir=1; stays until reset.
- data_dir=0 only during STA's MEM cycle.
- ISA (opcode hex; cycles):
  - 00 NOP (1)
  - 01 LDI i (2): A=i
  - 0C ADDI i (2): A=A+i
  - 02 LDA a (4): A=M[a]
  - 03 STA a (4): M[a]=A
  - 04 ADD a (4): A=A+M
  - 05 SUB a (4): A=A-M
  - 06 AND a (4)
  - 07 OR a (4)
  - 08 XOR a (4)
  - 09 JMP a (3)
  - 0A JZ a (3)
  - 0B JC a (3)
  - 0F HLT (1)
  - All other opcodes: NOP.
- Address operands are little-endian (low byte first).
- Flags:
  - Z=(result==0) on every A write: LDI, LDA, ALU ops.
  - C=carry-out of 8-bit ADD/ADDI.
  - C=borrow (A<M) for SUB.
  - C unchanged by logic ops and loads.
  - STA, jumps and NOP leave flags unchanged.
- Arithmetic is 8-bit modulo 256.
- Reset asserted mid-instruction aborts it. No memory write occurs in the reset cycle.

Optional Feature:
- Macro ATTOCORE_HALT_EN.
  - Defined: opcode 0F enters HALT; PC stays at the address following HLT; bus idles reading that address.
  - Undefined: 0F decodes as NOP; the HALT state is not built.

Test Plan:
- Reset: hold reset=1 for 2 cycles -> address_bus=0000, data_dir=1, data_bus high-Z. First FETCH after release reads address 0000.
- LDI/ADDI: ROM 01 7F 0C 01 -> A=80, Z=0, C=0 after 4 cycles. Then 0C 80 -> A=00, Z=1, C=1.
- STA: ROM 01 5A 03 F0 00 -> exactly one cycle with data_dir=0, address_bus=00F0, data_bus=5A, on the 6th cycle after reset release.
- LDA/SUB: M[F1]=03, program 01 02 05 F1 00 -> A=FF, C=1, Z=0. Then 0A xx xx is not taken (PC advances by 3).
- JMP loop: ROM 0C 01 09 00 00 repeated for 40 cycles -> A increments every 5 cycles. address_bus cycles 0000,0001,0002,0003,0004.
- HLT (ATTOCORE_HALT_EN set): ROM 01 11 0F -> address_bus frozen at 0003, A=11 indefinitely. With the macro unset, PC keeps incrementing.

Source files
------------

// File: rtl/attocore_cpu_if.sv
// Memory bus of attocore_cpu: 16-bit address, read/write direction and a shared tri-state 8-bit data bus.
// Both bus drivers resolve here. The core drives during writes (data_dir=0) and memory drives during reads.
interface attocore_cpu_if;
   logic [15:0] address_bus;
   logic        data_dir;
   logic [7:0]  cpu_dat;
   logic [7:0]  mem_dat;
   wire  [7:0]  data_bus;

   assign data_bus = data_dir ? 8'hzz   : cpu_dat;
   assign data_bus = data_dir ? mem_dat : 8'hzz;

   modport master (output address_bus, output data_dir, output cpu_dat, input data_bus);
   modport slave  (input address_bus, input data_dir, output mem_dat, input data_bus);
endinterface

// File: rtl/attocore_cpu.sv
// 8-bit accumulator CPU on a 16-bit bus. Each state takes one cycle: 1, 2, 3 or 4 cycles per instruction.
// The optional HALT state is built only when ATTOCORE_HALT_EN is defined. Without it, HLT (0F) runs as a NOP.
module attocore_cpu #(
   parameter logic [15:0] RESET_VECTOR = 16'h0000
) (
   input  logic           clock,
   input  logic           reset,
   attocore_cpu_if.master bus
);
   typedef enum logic [2:0] {
      S_FETCH = 3'd0,
      S_IMM   = 3'd1,
      S_ALO   = 3'd2,
      S_AHI   = 3'd3,
      S_MEM   = 3'd4
`ifdef ATTOCORE_HALT_EN
      , S_HALT = 3'd5
`endif
   } state_t;

   localparam logic [7:0] OP_LDI  = 8'h01;
   localparam logic [7:0] OP_LDA  = 8'h02;
   localparam logic [7:0] OP_STA  = 8'h03;
   localparam logic [7:0] OP_ADD  = 8'h04;
   localparam logic [7:0] OP_SUB  = 8'h05;
   localparam logic [7:0] OP_AND  = 8'h06;
   localparam logic [7:0] OP_OR   = 8'h07;
   localparam logic [7:0] OP_XOR  = 8'h08;
   localparam logic [7:0] OP_JMP  = 8'h09;
   localparam logic [7:0] OP_JZ   = 8'h0A;
   localparam logic [7:0] OP_JC   = 8'h0B;
   localparam logic [7:0] OP_ADDI = 8'h0C;
`ifdef ATTOCORE_HALT_EN
   localparam logic [7:0] OP_HLT  = 8'h0F;
`endif

   state_t      state_q, state_d;
   logic [15:0] pc_q, pc_d, op_q, op_d;
   logic [7:0]  a_q, a_d, ir_q, ir_d;
   logic        z_q, z_d, c_q, c_d;

   logic [15:0] pc_inc;
   logic [15:0] addr;
   logic        dir;
   logic [8:0]  alu_sum, alu_dif;
   logic [7:0]  alu_res;
   logic        alu_c, alu_wr, jmp_taken;

   assign pc_inc  = pc_q + 16'd1;
   assign alu_sum = {1'b0, a_q} + {1'b0, bus.data_bus};
   // Bit 8 of the 9-bit difference is the borrow, i.e. A < M.
   assign alu_dif = {1'b0, a_q} - {1'b0, bus.data_bus};

   always_comb begin
      alu_res = a_q;
      alu_c   = c_q;
      alu_wr  = 1'b0;
      case (ir_q)
         OP_LDI, OP_LDA: begin alu_res = bus.data_bus;      alu_wr = 1'b1; end
         OP_ADDI, OP_ADD: begin {alu_c, alu_res} = alu_sum; alu_wr = 1'b1; end
         OP_SUB:         begin {alu_c, alu_res} = alu_dif;  alu_wr = 1'b1; end
         OP_AND:         begin alu_res = a_q & bus.data_bus; alu_wr = 1'b1; end
         OP_OR:          begin alu_res = a_q | bus.data_bus; alu_wr = 1'b1; end
         OP_XOR:         begin alu_res = a_q ^ bus.data_bus; alu_wr = 1'b1; end
         default: ;
      endcase
   end

   always_comb begin
      case (ir_q)
         OP_JMP:  jmp_taken = 1'b1;
         OP_JZ:   jmp_taken = z_q;
         OP_JC:   jmp_taken = c_q;
         default: jmp_taken = 1'b0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      a_d     = a_q;
      z_d     = z_q;
      c_d     = c_q;
      ir_d    = ir_q;
      op_d    = op_q;
      addr    = pc_q;
      dir     = 1'b1;
      case (state_q)
         S_FETCH: begin
            ir_d = bus.data_bus;
            pc_d = pc_inc;
            if (bus.data_bus == OP_LDI || bus.data_bus == OP_ADDI)
               state_d = S_IMM;
            else if (bus.data_bus >= OP_LDA && bus.data_bus <= OP_JC)
               state_d = S_ALO;
`ifdef ATTOCORE_HALT_EN
            else if (bus.data_bus == OP_HLT)
               state_d = S_HALT;
`endif
         end
         S_IMM: begin
            pc_d    = pc_inc;
            a_d     = alu_res;
            z_d     = (alu_res == 8'h00);
            c_d     = alu_c;
            state_d = S_FETCH;
         end
         S_ALO: begin
            op_d[7:0] = bus.data_bus;
            pc_d      = pc_inc;
            state_d   = S_AHI;
         end
         S_AHI: begin
            op_d[15:8] = bus.data_bus;
            pc_d       = pc_inc;
            if (ir_q >= OP_JMP) begin
               if (jmp_taken)
                  pc_d = {bus.data_bus, op_q[7:0]};
               state_d = S_FETCH;
            end else begin
               state_d = S_MEM;
            end
         end
         S_MEM: begin
            addr    = op_q;
            dir     = (ir_q != OP_STA);
            state_d = S_FETCH;
            if (alu_wr) begin
               a_d = alu_res;
               z_d = (alu_res == 8'h00);
               c_d = alu_c;
            end
         end
`ifdef ATTOCORE_HALT_EN
         S_HALT: ;
`endif
         default: state_d = S_FETCH;
      endcase
   end

   // The reset override keeps the bus idle while reset is held, even mid-store.
   assign bus.address_bus = reset ? RESET_VECTOR : addr;
   assign bus.data_dir    = reset | dir;
   assign bus.cpu_dat     = a_q;

   always_ff @(posedge clock) begin
      if (reset)
         state_q <= S_FETCH;
      else
         state_q <= state_d;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pc_q <= RESET_VECTOR;
         a_q  <= 8'h00;
         z_q  <= 1'b0;
         c_q  <= 1'b0;
         ir_q <= 8'h00;
         op_q <= 16'h0000;
      end else begin
         pc_q <= pc_d;
         a_q  <= a_d;
         z_q  <= z_d;
         c_q  <= c_d;
         ir_q <= ir_d;
         op_q <= op_d;
      end
   end
endmodule

// File: tb/tb_attocore_cpu.sv
// Directed bench for attocore_cpu. A 256-byte memory answers combinationally and takes writes at the falling edge.
// Expected values are worked out by hand for each program.
module tb_attocore_cpu;
   logic clock = 1'b0;
   logic reset = 1'b1;

   attocore_cpu_if bus_if ();

   attocore_cpu #(.RESET_VECTOR(16'h0000)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus_if)
   );

   logic [7:0]  mem [256];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          edges    = 0;
   int          wr_cnt   = 0;
   int          wr_cyc   = 0;
   logic [15:0] wr_addr  = 16'h0000;
   logic [7:0]  wr_dat   = 8'h00;

   always #5 clock = ~clock;

   assign bus_if.mem_dat = mem[bus_if.address_bus[7:0]];

   always @(posedge clock) begin
      if (reset) edges <= 0;
      else       edges <= edges + 1;
   end

   // Writes land at the falling edge, after address, direction and data have settled.
   always @(negedge clock) begin
      if (!bus_if.data_dir) begin
         mem[bus_if.address_bus[7:0]] = bus_if.data_bus;
         wr_cnt  = wr_cnt + 1;
         wr_addr = bus_if.address_bus;
         wr_dat  = bus_if.data_bus;
         wr_cyc  = edges + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // Hold reset for two edges, check the idle bus, then release at a falling edge.
   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      check("rst_addr", 32'(bus_if.address_bus), 32'h0000);
      check("rst_dir",  32'(bus_if.data_dir),    32'h1);
      check("rst_a",    32'(dut.a_q),            32'h00);
      check("rst_zc",   32'({dut.z_q, dut.c_q}), 32'h0);
      @(negedge clock);
      reset  = 1'b0;
      wr_cnt = 0;
      #1;
      check("first_fetch_addr", 32'(bus_if.address_bus), 32'h0000);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // LDI/ADDI: carry-free sum, then a wrap to zero that sets Z and C.
      reset = 1'b1;
      clear_mem();
      mem[0] = 8'h01; mem[1] = 8'h7F; mem[2] = 8'h0C; mem[3] = 8'h01;
      mem[4] = 8'h0C; mem[5] = 8'h80;
      do_reset();
      step(4);
      check("addi_a", 32'(dut.a_q), 32'h80);
      check("addi_z", 32'(dut.z_q), 32'h0);
      check("addi_c", 32'(dut.c_q), 32'h0);
      step(2);
      check("addi_wrap_a", 32'(dut.a_q), 32'h00);
      check("addi_wrap_z", 32'(dut.z_q), 32'h1);
      check("addi_wrap_c", 32'(dut.c_q), 32'h1);

      // STA aborted by reset during its store cycle. No write may happen.
      reset = 1'b1;
      clear_mem();
      mem[0] = 8'h01; mem[1] = 8'h5A; mem[2] = 8'h03; mem[3] = 8'hF0; mem[4] = 8'h00;
      do_reset();
      step(5);
      check("sta_abort_dir_before", 32'(bus_if.data_dir), 32'h0);
      reset = 1'b1;
      #1;
      check("sta_abort_dir",  32'(bus_if.data_dir),    32'h1);
      check("sta_abort_addr", 32'(bus_if.address_bus), 32'h0000);
      step(2);
      check("sta_abort_wr_cnt", 32'(wr_cnt),    32'd0);
      check("sta_abort_mem",    32'(mem[8'hF0]), 32'h00);

      // STA runs to completion: a single write cycle, the 6th after release.
      do_reset();
      step(10);
      check("sta_wr_cnt", 32'(wr_cnt),     32'd1);
      check("sta_addr",   32'(wr_addr),    32'h00F0);
      check("sta_data",   32'(wr_dat),     32'h5A);
      check("sta_cycle",  32'(wr_cyc),     32'd6);
      check("sta_mem",    32'(mem[8'hF0]), 32'h5A);

      // LDA-free SUB with borrow, JZ not taken, then JC taken.
      reset = 1'b1;
      clear_mem();
      mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h05; mem[3] = 8'hF1; mem[4] = 8'h00;
      mem[5] = 8'h0A; mem[6] = 8'h40; mem[7] = 8'h00;
      mem[8] = 8'h0B; mem[9] = 8'h20; mem[10] = 8'h00;
      mem[8'hF1] = 8'h03;
      do_reset();
      step(6);
      check("sub_a", 32'(dut.a_q), 32'hFF);
      check("sub_c", 32'(dut.c_q), 32'h1);
      check("sub_z", 32'(dut.z_q), 32'h0);
      step(3);
      check("jz_not_taken_addr", 32'(bus_if.address_bus), 32'h0008);
      step(3);
      check("jc_taken_addr", 32'(bus_if.address_bus), 32'h0020);

      // Logic ops keep C; XOR to zero sets Z; ADD of FF onto 00 has no carry.
      reset = 1'b1;
      clear_mem();
      mem[0]  = 8'h01; mem[1]  = 8'hF0; mem[2]  = 8'h0C; mem[3]  = 8'h20;
      mem[4]  = 8'h06; mem[5]  = 8'hE0; mem[6]  = 8'h00;
      mem[7]  = 8'h07; mem[8]  = 8'hE1; mem[9]  = 8'h00;
      mem[10] = 8'h08; mem[11] = 8'hE2; mem[12] = 8'h00;
      mem[13] = 8'h04; mem[14] = 8'hE3; mem[15] = 8'h00;
      mem[8'hE0] = 8'h3C; mem[8'hE1] = 8'h0F; mem[8'hE2] = 8'h1F; mem[8'hE3] = 8'hFF;
      do_reset();
      step(8);
      check("and_a", 32'(dut.a_q), 32'h10);
      check("and_c", 32'(dut.c_q), 32'h1);
      step(4);
      check("or_a", 32'(dut.a_q), 32'h1F);
      step(4);
      check("xor_a", 32'(dut.a_q), 32'h00);
      check("xor_z", 32'(dut.z_q), 32'h1);
      check("xor_c", 32'(dut.c_q), 32'h1);
      step(4);
      check("add_a", 32'(dut.a_q), 32'hFF);
      check("add_c", 32'(dut.c_q), 32'h0);
      check("add_z", 32'(dut.z_q), 32'h0);

      // JMP loop: five-address cycle, one increment per pass.
      reset = 1'b1;
      clear_mem();
      mem[0] = 8'h0C; mem[1] = 8'h01; mem[2] = 8'h09; mem[3] = 8'h00; mem[4] = 8'h00;
      do_reset();
      for (int i = 0; i < 40; i++) begin
         check("jmp_loop_addr", 32'(bus_if.address_bus), 32'(i % 5));
         step(1);
      end
      check("jmp_loop_a", 32'(dut.a_q), 32'h08);

      // HLT: the bus parks at the address after HLT, or execution runs on through NOPs.
      reset = 1'b1;
      clear_mem();
      mem[0] = 8'h01; mem[1] = 8'h11; mem[2] = 8'h0F;
      do_reset();
      step(3);
      check("hlt_addr", 32'(bus_if.address_bus), 32'h0003);
      step(10);
`ifdef ATTOCORE_HALT_EN
      check("hlt_frozen_addr", 32'(bus_if.address_bus), 32'h0003);
`else
      check("hlt_as_nop_addr", 32'(bus_if.address_bus), 32'h000D);
`endif
      check("hlt_a",   32'(dut.a_q),         32'h11);
      check("hlt_dir", 32'(bus_if.data_dir), 32'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
